// File: rtl/bram_burst_reader_if.sv
// Command, RAM read-port and output-stream signals of the burst reader.
// The slave modport is the reader's view; master is the requester/consumer/RAM side.
interface bram_burst_reader_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 11
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [ADDRESS_WIDTH-1:0] cmd_addr;
  logic [ADDRESS_WIDTH-1:0] cmd_len_m1;
  logic [ADDRESS_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0]    mem_dout;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_last;
  logic                     busy;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len_m1, mem_dout, out_ready,
    output cmd_ready, mem_raddr, out_valid, out_data, out_last, busy
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len_m1, mem_dout, out_ready,
    input  cmd_ready, mem_raddr, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/bram_burst_reader.sv
// Burst reader for a 1-cycle registered-output RAM: issue -> push 2 edges later, 1 beat/cycle.
// Backpressure: reads issue only while fifo_count + inflight < 4, so the 4-entry FIFO never overflows.
module bram_burst_reader #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 11
) (
  input logic                clock,
  input logic                reset,
  bram_burst_reader_if.slave bus
);
  localparam int DEPTH = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] addr, remaining, raddr;
  logic [1:0]               pipe_vld, pipe_last;
  logic [DATA_WIDTH-1:0]    fifo_data [DEPTH];
  logic                     fifo_last [DEPTH];
  logic [1:0]               wr_ptr, rd_ptr;
  logic [2:0]               count;
  logic [1:0]               inflight;
  logic                     cmd_ready, accept, issue, push, pop, credit_ok, not_empty;

  assign inflight  = {1'b0, pipe_vld[0]} + {1'b0, pipe_vld[1]};
  assign credit_ok = (count + {1'b0, inflight}) < 3'(DEPTH);
  assign not_empty = (count != 3'd0);
  assign cmd_ready = (state == IDLE) && !reset;
  assign accept    = bus.cmd_valid && cmd_ready;
  assign push      = pipe_vld[1];
  assign pop       = not_empty && bus.out_ready;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = RUN;
      RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (remaining == '0) state_nxt = DRAIN;
        end
      end
      DRAIN: if (!not_empty && pipe_vld == 2'b00) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The last flag rides alongside the valid bit so it reaches the FIFO with its beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
      raddr     <= '0;
      pipe_vld  <= 2'b00;
      pipe_last <= 2'b00;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      count     <= 3'd0;
    end else begin
      if (accept) begin
        addr      <= bus.cmd_addr;
        remaining <= bus.cmd_len_m1;
      end else if (issue) begin
        raddr     <= addr;
        addr      <= addr + ADDRESS_WIDTH'(1);
        remaining <= remaining - ADDRESS_WIDTH'(1);
      end
      pipe_vld  <= {pipe_vld[0], issue};
      pipe_last <= {pipe_last[0], issue && (remaining == '0)};
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.mem_dout;
      fifo_last[wr_ptr] <= pipe_last[1];
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.mem_raddr = raddr;
  assign bus.out_valid = not_empty;
  assign bus.out_data  = fifo_data[rd_ptr];
  assign bus.out_last  = not_empty && fifo_last[rd_ptr];
  assign bus.busy      = (state != IDLE);

  overflow_chk: assert property (@(posedge clock) disable iff (reset)
    !(push && !pop && count == 3'(DEPTH)));
endmodule

// File: tb/tb_bram_burst_reader.sv
// Bench for bram_burst_reader: write-first RAM model, directed and random bursts
// checked against a queue of expected beats built from the memory contents.
module tb_bram_burst_reader;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int N  = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bram_burst_reader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();
  bram_burst_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [DW-1:0] ram       [N];
  logic [DW-1:0] model_mem [N];
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  int            checks   = 0;
  int            failures = 0;

  // Registered-output RAM; a write to the address being read returns the new word.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) ram[i] <= 16'(16'h0100 + i);
    end else if (we) begin
      ram[waddr] <= wdata;
    end
    bus.mem_dout <= (we && waddr == bus.mem_raddr) ? wdata : ram[bus.mem_raddr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [AW-1:0] l);
    int n = 0;
    @(negedge clock);
    bus.cmd_valid  = 1'b1;
    bus.cmd_addr   = a;
    bus.cmd_len_m1 = l;
    while (!bus.cmd_ready && n < 400) begin
      @(negedge clock);
      n++;
    end
    check_eq("cmd_ready_wait", bus.cmd_ready, 1);
    @(posedge clock);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!bus.cmd_ready && n < 6) begin
      @(negedge clock);
      n++;
    end
    check_eq($sformatf("%s.idle_ready", tag), bus.cmd_ready, 1);
    check_eq($sformatf("%s.idle_busy", tag), bus.busy, 0);
  endtask

  // mode: 0 steady ready, 1 stall 6 cycles after first beat, 2 random ready, 3 write-first at addr 3
  task automatic run_burst(input int a, input int l, input int mode, input int stop_after,
                           input bit hold_next, input bit chk_raddr, input string tag);
    logic [DW-1:0] exp_d[$], got_d[$];
    bit            exp_l[$], got_l[$];
    int            got_ra[$];
    int            target, e, first_valid, first_pop, last_pop, issued, stall, max_out;
    logic [AW-1:0] prev_ra;
    bit            written, stall_checked, cmd_leak;
    first_valid = -1; first_pop = 0; last_pop = 0; issued = 0; stall = 0; max_out = 0;
    written = 0; stall_checked = 0; cmd_leak = 0;
    if (mode == 3) model_mem[3] = 16'hBEEF;
    for (int i = 0; i <= l; i++) begin
      exp_d.push_back(model_mem[(a + i) % N]);
      exp_l.push_back(i == l);
    end
    target = (stop_after > 0) ? stop_after : l + 1;
    send_cmd(a[AW-1:0], l[AW-1:0]);
    if (hold_next) begin
      bus.cmd_valid  = 1'b1;
      bus.cmd_addr   = 4'd9;
      bus.cmd_len_m1 = 4'd0;
    end
    prev_ra = bus.mem_raddr;
    e = 0;
    bus.out_ready = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    while (got_d.size() < target && e < 400) begin
      @(negedge clock);
      if (bus.mem_raddr != prev_ra) begin
        issued++;
        got_ra.push_back(int'(bus.mem_raddr));
        prev_ra = bus.mem_raddr;
      end
      if (issued - got_d.size() > max_out) max_out = issued - got_d.size();
      if (bus.cmd_valid && bus.busy && bus.cmd_ready) cmd_leak = 1;
      if (bus.out_valid && first_valid < 0) first_valid = e;
      if (mode == 1 && !stall_checked && stall == 0 && !bus.out_ready) begin
        check_eq($sformatf("%s.stall_issued", tag), issued, 5);
        stall_checked = 1;
      end
      if (mode == 3 && !written && issued > 0 && bus.mem_raddr == 4'd3) begin
        we = 1'b1; waddr = 4'd3; wdata = 16'hBEEF; written = 1;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (got_d.size() == 0) first_pop = e;
        last_pop = e;
        got_d.push_back(bus.out_data);
        got_l.push_back(bus.out_last);
        if (mode == 1 && got_d.size() == 1) stall = 6;
      end
      if (got_d.size() < target) begin
        @(posedge clock);
        #1;
        e++;
        we = 1'b0;
        if (stall > 0) begin
          bus.out_ready = 1'b0;
          stall--;
        end else begin
          bus.out_ready = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end
    end
    check_eq($sformatf("%s.beats", tag), got_d.size(), target);
    for (int i = 0; i < got_d.size() && i < target; i++) begin
      check_eq($sformatf("%s.data%0d", tag, i), got_d[i], exp_d[i]);
      check_eq($sformatf("%s.last%0d", tag, i), got_l[i], exp_l[i]);
    end
    if (stop_after <= 0) begin
      check_eq($sformatf("%s.max_outstanding_le4", tag), max_out <= 4, 1);
      if (mode == 0 || mode == 3) begin
        check_eq($sformatf("%s.first_valid_lat", tag), first_valid, 3);
        check_eq($sformatf("%s.back_to_back", tag), last_pop - first_pop, l);
      end
      if (chk_raddr) begin
        check_eq($sformatf("%s.raddr_count", tag), got_ra.size(), l + 1);
        for (int i = 0; i < got_ra.size() && i <= l; i++)
          check_eq($sformatf("%s.raddr%0d", tag, i), got_ra[i], (a + i) % N);
      end
      if (hold_next) check_eq($sformatf("%s.cmd_ignored_busy", tag), cmd_leak, 0);
      else           wait_idle(tag);
    end
    bus.out_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) model_mem[i] = 16'(16'h0100 + i);
    we = 1'b0; waddr = '0; wdata = '0;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len_m1 = '0; bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst.out_valid", bus.out_valid, 0);
    check_eq("rst.out_last", bus.out_last, 0);
    check_eq("rst.busy", bus.busy, 0);
    check_eq("rst.mem_raddr", bus.mem_raddr, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_eq("post_rst.cmd_ready", bus.cmd_ready, 1);

    run_burst(2, 3, 0, 0, 0, 0, "single");
    run_burst(14, 3, 0, 0, 0, 1, "wrap");
    run_burst(0, 7, 1, 0, 0, 0, "backpressure");
    run_burst(5, 15, 0, 0, 0, 1, "full_mem");

    run_burst(10, 9, 0, 2, 0, 0, "abort");
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_eq("abort.out_valid", bus.out_valid, 0);
    check_eq("abort.busy", bus.busy, 0);
    check_eq("abort.out_last", bus.out_last, 0);
    check_eq("abort.mem_raddr", bus.mem_raddr, 0);
    check_eq("abort.cmd_ready", bus.cmd_ready, 1);
    run_burst(8, 0, 0, 0, 0, 0, "after_abort");

    run_burst(1, 4, 3, 0, 1, 0, "write_first");
    run_burst(9, 0, 0, 0, 0, 0, "held_cmd");

    for (int k = 0; k < 20; k++)
      run_burst(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 2, 0, 0, 0,
                $sformatf("rnd%0d", k));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
